// File: rtl/chess_pkg.sv
// Shared chess encodings: piece nibbles, colours, knight directions and FSM states.
package chess_pkg;

  localparam int unsigned SQ_W    = 6;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned NUM_SQ  = 64;
  localparam int unsigned BOARD_W = NUM_SQ * NIB_W;
  localparam int unsigned DIR_W   = 3;
  localparam int unsigned CNT_W   = 4;

  // Nibble layout: bit3 = colour, bits[2:0] = piece type.
  localparam int unsigned NIB_COLOUR_BIT = 3;
  localparam int unsigned NIB_TYPE_LSB   = 0;
  localparam int unsigned NIB_TYPE_W     = 3;

  localparam logic [NIB_TYPE_W-1:0] PT_EMPTY  = 3'd0;
  localparam logic [NIB_TYPE_W-1:0] PT_PAWN   = 3'd1;
  localparam logic [NIB_TYPE_W-1:0] PT_KNIGHT = 3'd2;
  localparam logic [NIB_TYPE_W-1:0] PT_BISHOP = 3'd3;
  localparam logic [NIB_TYPE_W-1:0] PT_ROOK   = 3'd4;
  localparam logic [NIB_TYPE_W-1:0] PT_QUEEN  = 3'd5;
  localparam logic [NIB_TYPE_W-1:0] PT_KING   = 3'd6;

  localparam logic COLOUR_WHITE = 1'b0;
  localparam logic COLOUR_BLACK = 1'b1;

  // Knight direction codes, walked in ascending order.
  localparam logic [DIR_W-1:0] KDIR_FIRST = 3'd0;
  localparam logic [DIR_W-1:0] KDIR_LAST  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } gen_state_e;

  // Move payload presented on the output handshake.
  typedef struct packed {
    logic [SQ_W-1:0]  to;
    logic             capture;
    logic [DIR_W-1:0] dir;
  } move_t;

  // Row offset of each knight direction (row 0 is the top rank).
  function automatic logic signed [3:0] knight_drow(input logic [DIR_W-1:0] d);
    case (d)
      3'd0:    return -4'sd1;
      3'd1:    return -4'sd2;
      3'd2:    return -4'sd2;
      3'd3:    return -4'sd1;
      3'd4:    return  4'sd1;
      3'd5:    return  4'sd2;
      3'd6:    return  4'sd2;
      default: return  4'sd1;
    endcase
  endfunction

  // Column offset of each knight direction.
  function automatic logic signed [3:0] knight_dcol(input logic [DIR_W-1:0] d);
    case (d)
      3'd0:    return -4'sd2;
      3'd1:    return -4'sd1;
      3'd2:    return  4'sd1;
      3'd3:    return  4'sd2;
      3'd4:    return  4'sd2;
      3'd5:    return  4'sd1;
      3'd6:    return -4'sd1;
      default: return -4'sd2;
    endcase
  endfunction

  function automatic logic nib_colour(input logic [NIB_W-1:0] n);
    return n[NIB_COLOUR_BIT];
  endfunction

  function automatic logic [NIB_TYPE_W-1:0] nib_type(input logic [NIB_W-1:0] n);
    return n[NIB_TYPE_LSB +: NIB_TYPE_W];
  endfunction

endpackage

// File: rtl/knight_target.sv
// Combinational knight target: source square + direction -> target square and on-board flag.
module knight_target
  import chess_pkg::*;
(
  input  logic [SQ_W-1:0]  from_square_i,
  input  logic [DIR_W-1:0] dir_i,
  output logic [SQ_W-1:0]  to_square_o,
  output logic             in_bounds_o
);

  logic signed [3:0] row_s;
  logic signed [3:0] col_s;
  logic signed [3:0] trow_s;
  logic signed [3:0] tcol_s;

  // Signed row/col stepping; results of -2,-1,8,9 all land with bit3 set, so bit3 means off board.
  always_comb begin
    row_s       = {1'b0, from_square_i[5:3]};
    col_s       = {1'b0, from_square_i[2:0]};
    trow_s      = row_s + knight_drow(dir_i);
    tcol_s      = col_s + knight_dcol(dir_i);
    in_bounds_o = !trow_s[3] && !tcol_s[3];
    to_square_o = {trow_s[2:0], tcol_s[2:0]};
  end

endmodule

// File: rtl/knight_move_gen.sv
// Knight move generator: snapshots a board, walks 8 knight directions and streams legal moves.
module knight_move_gen
  import chess_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BOARD_W-1:0] bigBoard,
  input  logic [SQ_W-1:0]    fromSquare,
  input  logic               side,
  output logic               moveValid,
  input  logic               moveReady,
  output logic [SQ_W-1:0]    moveTo,
  output logic               moveCapture,
  output logic [DIR_W-1:0]   moveDir,
  output logic [NUM_SQ-1:0]  moveMask,
  output logic [NUM_SQ-1:0]  captureMask,
  output logic [CNT_W-1:0]   moveCount,
  output logic               givesCheck,
  output logic               busy,
  output logic               done,
  output logic               err
);

  gen_state_e         state_q, state_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic [BOARD_W-1:0] board_q, board_d;
  logic [SQ_W-1:0]    from_q, from_d;
  logic               side_q, side_d;
  logic [NUM_SQ-1:0]  mask_q, mask_d;
  logic [NUM_SQ-1:0]  cap_q, cap_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               check_q, check_d;
  logic               err_q, err_d;

  logic [SQ_W-1:0]  to_sq;
  logic             in_bounds;
  logic [NIB_W-1:0] src_nib;
  logic [NIB_W-1:0] tgt_nib;
  logic             src_ok;
  logic             in_scan;
  logic             tgt_empty;
  logic             tgt_enemy;
  logic             tgt_king;
  logic             legal;
  logic             check_hit;
  move_t            move_c;

  knight_target u_target (
    .from_square_i (from_q),
    .dir_i         (dir_q),
    .to_square_o   (to_sq),
    .in_bounds_o   (in_bounds)
  );

  // Classify the current direction's target square from the snapshot.
  always_comb begin
    src_nib   = board_q[{from_q, 2'b00} +: NIB_W];
    tgt_nib   = board_q[{to_sq, 2'b00} +: NIB_W];
    src_ok    = (src_nib == {side_q, PT_KNIGHT});
    in_scan   = (state_q == ST_SCAN);
    tgt_empty = (tgt_nib == NIB_W'(0));
    tgt_enemy = !tgt_empty && (nib_colour(tgt_nib) != side_q);
    tgt_king  = (nib_type(tgt_nib) == PT_KING);
    legal     = in_scan && src_ok && in_bounds && (tgt_empty || (tgt_enemy && !tgt_king));
    check_hit = in_scan && src_ok && in_bounds && tgt_enemy && tgt_king;
    move_c    = '0;
    if (legal) begin
      move_c.to      = to_sq;
      move_c.capture = !tgt_empty;
      move_c.dir     = dir_q;
    end
  end

  // Next-state and accumulator update.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    board_d = board_q;
    from_d  = from_q;
    side_d  = side_q;
    mask_d  = mask_q;
    cap_d   = cap_q;
    count_d = count_q;
    check_d = check_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          board_d = bigBoard;
          from_d  = fromSquare;
          side_d  = side;
          mask_d  = '0;
          cap_d   = '0;
          count_d = '0;
          check_d = 1'b0;
          err_d   = 1'b0;
          dir_d   = KDIR_FIRST;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!src_ok) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          if (check_hit) begin
            check_d = 1'b1;
          end
          if (legal && moveReady) begin
            mask_d[move_c.to] = 1'b1;
            if (move_c.capture) begin
              cap_d[move_c.to] = 1'b1;
            end
            count_d = count_q + CNT_W'(1);
          end
          if (!legal || moveReady) begin
            if (dir_q == KDIR_LAST) begin
              state_d = ST_DONE;
            end else begin
              dir_d = dir_q + DIR_W'(1);
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and accumulator registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= '0;
      board_q <= '0;
      from_q  <= '0;
      side_q  <= 1'b0;
      mask_q  <= '0;
      cap_q   <= '0;
      count_q <= '0;
      check_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      board_q <= board_d;
      from_q  <= from_d;
      side_q  <= side_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      count_q <= count_d;
      check_q <= check_d;
      err_q   <= err_d;
    end
  end

  assign moveValid   = legal;
  assign moveTo      = move_c.to;
  assign moveCapture = move_c.capture;
  assign moveDir     = move_c.dir;
  assign moveMask    = mask_q;
  assign captureMask = cap_q;
  assign moveCount   = count_q;
  assign givesCheck  = check_q;
  assign err         = err_q;
  assign busy        = in_scan;
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_knight_move_gen.sv
// Randomised self-checking bench for knight_move_gen against a square/offset reference model.
module tb_knight_move_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] bigBoard;
  logic [5:0]   fromSquare;
  logic         side;
  logic         moveValid;
  logic         moveReady;
  logic [5:0]   moveTo;
  logic         moveCapture;
  logic [2:0]   moveDir;
  logic [63:0]  moveMask;
  logic [63:0]  captureMask;
  logic [3:0]   moveCount;
  logic         givesCheck;
  logic         busy;
  logic         done;
  logic         err;

  int tests_run = 0;
  int fails     = 0;

  always #5 clk = ~clk;

  knight_move_gen dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bigBoard    (bigBoard),
    .fromSquare  (fromSquare),
    .side        (side),
    .moveValid   (moveValid),
    .moveReady   (moveReady),
    .moveTo      (moveTo),
    .moveCapture (moveCapture),
    .moveDir     (moveDir),
    .moveMask    (moveMask),
    .captureMask (captureMask),
    .moveCount   (moveCount),
    .givesCheck  (givesCheck),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  // Reference model results
  int          exp_to[$];
  int          exp_dir[$];
  int          exp_cap[$];
  logic [63:0] exp_mask;
  logic [63:0] exp_capm;
  int          exp_cnt;
  bit          exp_chk;
  bit          exp_err;

  // Observed run results
  int          obs_to[$];
  int          obs_dir[$];
  int          obs_cap[$];
  int          done_cyc;
  int          stall_cycles;
  bit          hold_bad;
  bit          timed_out;
  logic [63:0] fin_mask;
  logic [63:0] fin_capm;
  logic [3:0]  fin_cnt;
  logic        fin_chk;
  logic        fin_err;

  logic [255:0] brd;

  // Chess rules: knight offsets, board edges, empty/enemy/king classification.
  function automatic void model(input logic [255:0] b, input int f, input int s);
    int dr[8] = '{-1, -2, -2, -1, 1, 2, 2, 1};
    int dc[8] = '{-2, -1, 1, 2, 2, 1, -1, -2};
    int r, c, t, n, src;
    exp_to.delete(); exp_dir.delete(); exp_cap.delete();
    exp_mask = '0; exp_capm = '0; exp_cnt = 0; exp_chk = 0; exp_err = 0;
    src = int'(b[f*4 +: 4]);
    if (src != s * 8 + 2) begin
      exp_err = 1;
      return;
    end
    for (int d = 0; d < 8; d++) begin
      r = f / 8 + dr[d];
      c = f % 8 + dc[d];
      if (r < 0 || r > 7 || c < 0 || c > 7) continue;
      t = r * 8 + c;
      n = int'(b[t*4 +: 4]);
      if (n == 0) begin
        exp_to.push_back(t); exp_dir.push_back(d); exp_cap.push_back(0);
        exp_mask[t] = 1'b1; exp_cnt++;
      end else if (n / 8 != s) begin
        if (n % 8 == 6) exp_chk = 1;
        else begin
          exp_to.push_back(t); exp_dir.push_back(d); exp_cap.push_back(1);
          exp_mask[t] = 1'b1; exp_capm[t] = 1'b1; exp_cnt++;
        end
      end
    end
  endfunction

  function automatic bit seq_match();
    if (obs_to.size() != exp_to.size()) return 0;
    foreach (exp_to[i])
      if (obs_to[i] != exp_to[i] || obs_dir[i] != exp_dir[i] || obs_cap[i] != exp_cap[i]) return 0;
    return 1;
  endfunction

  task automatic clear_board();
    brd = '0;
  endtask

  task automatic put(input int sq, input int nib);
    brd[sq*4 +: 4] = 4'(nib);
  endtask

  // Drives one generation and records what the DUT emits; cyc k = k-th cycle after the start edge.
  task automatic run_gen(input logic [255:0] b, input logic [5:0] f, input logic s,
                         input int stall_first, input bit rand_ready);
    int cyc;
    int stall;
    bit held;
    logic [5:0] held_to;
    logic [2:0] held_dir;
    logic held_cap;
    obs_to.delete(); obs_dir.delete(); obs_cap.delete();
    done_cyc = -1; stall_cycles = 0; hold_bad = 0; timed_out = 0;
    held = 0; held_to = '0; held_dir = '0; held_cap = 1'b0;
    stall = stall_first;
    @(posedge clk); #1;
    bigBoard = b; fromSquare = f; side = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int w = 0; w < 8; w++) bigBoard[w*32 +: 32] = $urandom;
    fromSquare = 6'($urandom);
    side = 1'($urandom);
    cyc = 1;
    forever begin
      if (moveValid) begin
        if (stall > 0) begin moveReady = 1'b0; stall--; end
        else if (rand_ready) moveReady = 1'($urandom_range(0, 1));
        else moveReady = 1'b1;
      end else begin
        moveReady = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (held && (!moveValid || moveTo !== held_to || moveDir !== held_dir || moveCapture !== held_cap))
        hold_bad = 1;
      held = 0;
      if (moveValid) begin
        if (moveReady) begin
          obs_to.push_back(int'(moveTo)); obs_dir.push_back(int'(moveDir));
          obs_cap.push_back(int'(moveCapture));
        end else begin
          held = 1; held_to = moveTo; held_dir = moveDir; held_cap = moveCapture;
          stall_cycles++;
        end
      end
      if (done) begin
        done_cyc = cyc;
        fin_mask = moveMask; fin_capm = captureMask; fin_cnt = moveCount;
        fin_chk = givesCheck; fin_err = err;
        break;
      end
      if (cyc >= 60) begin
        timed_out = 1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    moveReady = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; moveReady = 1'b0; bigBoard = '0; fromSquare = '0; side = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({moveValid, moveTo, moveCapture, moveDir, moveMask, captureMask, moveCount, givesCheck, err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%0b to=%0d mask=%h cnt=%0d err=%0b required all zero",
               moveValid, moveTo, moveMask, moveCount, err);
    end
    tests_run++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("FAIL reset_state: got busy=%0b done=%0b required 0 0", busy, done);
    end
  endtask

  task automatic test_corner();
    clear_board(); put(0, 2);
    model(brd, 0, 0);
    run_gen(brd, 6'd0, 1'b0, 0, 1'b0);
    tests_run++;
    if (!seq_match() || obs_to.size() != 2 || obs_to[0] != 10 || obs_to[1] != 17) begin
      fails++;
      $display("FAIL corner_seq: got %0d moves required 2 moves {10,17}", obs_to.size());
    end
    tests_run++;
    if (done_cyc != 9) begin
      fails++;
      $display("FAIL corner_done_latency: got %0d required 9", done_cyc);
    end
    tests_run++;
    if (fin_mask !== exp_mask || fin_cnt !== 4'(exp_cnt) || fin_capm !== '0) begin
      fails++;
      $display("FAIL corner_mask: got mask=%h cnt=%0d cap=%h required mask=%h cnt=%0d cap=0",
               fin_mask, fin_cnt, fin_capm, exp_mask, exp_cnt);
    end
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || moveMask !== exp_mask || moveCount !== 4'(exp_cnt)) begin
      fails++;
      $display("FAIL corner_idle_hold: got busy=%0b done=%0b mask=%h cnt=%0d required 0 0 %h %0d",
               busy, done, moveMask, moveCount, exp_mask, exp_cnt);
    end
  endtask

  task automatic test_center();
    clear_board(); put(27, 2);
    model(brd, 27, 0);
    run_gen(brd, 6'd27, 1'b0, 0, 1'b0);
    tests_run++;
    if (!seq_match() || obs_to.size() != 8) begin
      fails++;
      $display("FAIL center_seq: got %0d moves required 8 in direction order", obs_to.size());
    end
    tests_run++;
    if (fin_cnt !== 4'd8 || fin_capm !== '0 || fin_chk !== 1'b0 || done_cyc != 9) begin
      fails++;
      $display("FAIL center_summary: got cnt=%0d cap=%h chk=%0b done@%0d required 8 0 0 9",
               fin_cnt, fin_capm, fin_chk, done_cyc);
    end
  endtask

  task automatic test_mixed();
    clear_board(); put(27, 2); put(10, 1); put(44, 12); put(12, 14);
    model(brd, 27, 0);
    run_gen(brd, 6'd27, 1'b0, 0, 1'b0);
    tests_run++;
    if (!seq_match()) begin
      fails++;
      $display("FAIL mixed_seq: got %0d moves required %0d", obs_to.size(), exp_to.size());
    end
    tests_run++;
    if (fin_cnt !== 4'd6 || fin_chk !== 1'b1 || fin_capm !== (64'd1 << 44) || fin_mask !== exp_mask) begin
      fails++;
      $display("FAIL mixed_summary: got cnt=%0d chk=%0b cap=%h mask=%h required 6 1 %h %h",
               fin_cnt, fin_chk, fin_capm, fin_mask, 64'd1 << 44, exp_mask);
    end
  endtask

  task automatic test_backpressure();
    clear_board(); put(27, 2);
    model(brd, 27, 0);
    run_gen(brd, 6'd27, 1'b0, 3, 1'b0);
    tests_run++;
    if (done_cyc != 12 || stall_cycles != 3) begin
      fails++;
      $display("FAIL bp_latency: got done@%0d stalls=%0d required 12 3", done_cyc, stall_cycles);
    end
    tests_run++;
    if (hold_bad || !seq_match()) begin
      fails++;
      $display("FAIL bp_hold: got hold_bad=%0b moves=%0d required 0 %0d", hold_bad, obs_to.size(), exp_to.size());
    end
  endtask

  task automatic test_err();
    clear_board(); put(27, 3);
    model(brd, 27, 0);
    run_gen(brd, 6'd27, 1'b0, 0, 1'b0);
    tests_run++;
    if (fin_err !== 1'b1 || obs_to.size() != 0 || stall_cycles != 0 || done_cyc != 2) begin
      fails++;
      $display("FAIL err_bishop: got err=%0b moves=%0d done@%0d required 1 0 2", fin_err, obs_to.size(), done_cyc);
    end
  endtask

  task automatic test_random();
    int f, s;
    for (int it = 0; it < 30; it++) begin
      for (int sq = 0; sq < 64; sq++)
        brd[sq*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      f = $urandom_range(0, 63);
      s = $urandom_range(0, 1);
      if ($urandom_range(0, 3) != 0) brd[f*4 +: 4] = 4'(s * 8 + 2);
      model(brd, f, s);
      run_gen(brd, 6'(f), 1'(s), 0, 1'b1);
      tests_run++;
      if (timed_out || !seq_match() || hold_bad) begin
        fails++;
        $display("FAIL rand_seq[%0d]: got moves=%0d hold_bad=%0b timeout=%0b required moves=%0d", it,
                 obs_to.size(), hold_bad, timed_out, exp_to.size());
      end
      tests_run++;
      if (fin_mask !== exp_mask || fin_capm !== exp_capm || fin_cnt !== 4'(exp_cnt) ||
          fin_chk !== exp_chk || fin_err !== exp_err) begin
        fails++;
        $display("FAIL rand_summary[%0d]: got mask=%h cap=%h cnt=%0d chk=%0b err=%0b required %h %h %0d %0b %0b",
                 it, fin_mask, fin_capm, fin_cnt, fin_chk, fin_err, exp_mask, exp_capm, exp_cnt, exp_chk, exp_err);
      end
      tests_run++;
      if (done_cyc != (exp_err ? 2 : 9 + stall_cycles)) begin
        fails++;
        $display("FAIL rand_latency[%0d]: got %0d required %0d", it, done_cyc, exp_err ? 2 : 9 + stall_cycles);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    bit seq_ok;
    bit spurious;
    clear_board(); put(27, 2);
    model(brd, 27, 0);
    seq_ok = 1; spurious = 0;
    moveReady = 1'b1;
    @(posedge clk); #1;
    bigBoard = brd; fromSquare = 6'd27; side = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (!moveValid || int'(moveTo) != exp_to[c-1] || int'(moveDir) != exp_dir[c-1]) seq_ok = 0;
      @(posedge clk); #1;
    end
    tests_run++;
    if (!seq_ok) begin
      fails++;
      $display("FAIL start_during_busy: got restart or wrong order required moves 17,10,12 uninterrupted");
    end
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if ({moveValid, moveTo, moveCapture, moveDir, moveMask, captureMask, moveCount, givesCheck, err, busy, done} !== '0) begin
      fails++;
      $display("FAIL reset_mid_scan: got valid=%0b busy=%0b mask=%h cnt=%0d required all zero",
               moveValid, busy, moveMask, moveCount);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy || moveValid) spurious = 1;
    end
    tests_run++;
    if (spurious) begin
      fails++;
      $display("FAIL reset_no_done: got activity after reset required idle");
    end
  endtask

  initial begin
    test_reset();
    test_corner();
    test_center();
    test_mixed();
    test_backpressure();
    test_err();
    test_random();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
